// File: rtl/key_bias_loader_pkg.sv
// key_bias_loader_pkg: shared loader state encoding and default word type
package key_bias_loader_pkg;
  typedef enum logic {LOAD, FULL} loader_state_t;
  localparam int KB_WORD_W = 16;
  typedef logic [KB_WORD_W-1:0] word_t;
endpackage

// File: rtl/key_bias_param_ram.sv
// key_bias_param_ram: 1W/1R parameter RAM with the ROM-compatible 2-stage ce0 read pipeline
module key_bias_param_ram
  import key_bias_loader_pkg::*;
#(
  parameter int DEPTH      = 32,
  parameter int WORD_W     = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH) + 1,
  parameter int PTR_W      = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic [PTR_W-1:0]      i_waddr,
  input  logic [WORD_W-1:0]     i_wdata,
  input  logic                  i_ce0,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [WORD_W-1:0]     o_q
);
  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [WORD_W-1:0] r_t0, r_t1;
  logic [WORD_W-1:0] w_rd;
  // out-of-range reads are undefined by contract; returning zero keeps the index in bounds
  assign w_rd = i_addr < ADDR_WIDTH'(DEPTH) ? r_mem[i_addr[PTR_W-1:0]] : '0;
  assign o_q = r_t1;
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_t0 <= '0;
      r_t1 <= '0;
    end else if (i_ce0) begin
      r_t0 <= w_rd;
      r_t1 <= r_t0;
    end
  end
endmodule

// File: rtl/encoder_layer_2_attention_self_key_bias_loader.sv
// encoder_layer_2_attention_self_key_bias_loader: streams key biases into a RAM
// that is read back through the ROM-style address0/ce0/q0 port.
module encoder_layer_2_attention_self_key_bias_loader
  import key_bias_loader_pkg::*;
#(
  parameter int KEY_BIAS_TENSOR_SIZE_DIM_0 = 32,
  parameter int KEY_BIAS_PRECISION_0       = 16,
  parameter int KEY_BIAS_PARALLELISM_DIM_0 = 1,
  parameter int KEY_BIAS_PARALLELISM_DIM_1 = 1,
  parameter int PAR        = KEY_BIAS_PARALLELISM_DIM_0 * KEY_BIAS_PARALLELISM_DIM_1,
  parameter int DEPTH      = KEY_BIAS_TENSOR_SIZE_DIM_0 / KEY_BIAS_PARALLELISM_DIM_0,
  parameter int WORD_W     = KEY_BIAS_PRECISION_0 * PAR,
  parameter int ADDR_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [KEY_BIAS_PRECISION_0-1:0] data_in [PAR-1:0],
  input  logic                            data_in_valid,
  output logic                            data_in_ready,
  input  logic                            reload,
  output logic                            loaded,
  input  logic [ADDR_WIDTH-1:0]           address0,
  input  logic                            ce0,
  output logic [WORD_W-1:0]               q0
);
  localparam int P     = KEY_BIAS_PRECISION_0;
  localparam int PTR_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
  loader_state_t r_state, w_state_nxt;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [WORD_W-1:0] w_word;
  logic w_xfer, w_last;
  for (genvar j = 0; j < PAR; j++) begin : g_pack
    assign w_word[P*j +: P] = data_in[j];
  end
  assign data_in_ready = r_state == LOAD;
  assign loaded        = r_state == FULL;
  // a reload in the same cycle as a beat drops that beat
  assign w_xfer = data_in_valid && data_in_ready && !reload;
  assign w_last = r_wr_ptr == PTR_W'(DEPTH - 1);
  always_comb begin
    w_state_nxt = reload ? LOAD : (w_xfer && w_last) ? FULL : r_state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= LOAD;
      r_wr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_wr_ptr <= reload ? '0 : w_xfer ? (w_last ? '0 : r_wr_ptr + 1'b1) : r_wr_ptr;
    end
  end
  key_bias_param_ram #(
    .DEPTH(DEPTH), .WORD_W(WORD_W), .ADDR_WIDTH(ADDR_WIDTH), .PTR_W(PTR_W)
  ) u_ram (
    .clk(clk), .rst(rst), .i_we(w_xfer), .i_waddr(r_wr_ptr), .i_wdata(w_word),
    .i_ce0(ce0), .i_addr(address0), .o_q(q0)
  );
endmodule

// File: tb/tb_encoder_layer_2_attention_self_key_bias_loader.sv
// tb_encoder_layer_2_attention_self_key_bias_loader: scoreboard bench for the key-bias loader
module tb_encoder_layer_2_attention_self_key_bias_loader;
  import key_bias_loader_pkg::*;
  logic clk = 0;
  logic rst = 1;
  logic [15:0] data_in [0:0];
  logic data_in_valid = 0, reload = 0, ce0 = 0;
  logic data_in_ready, loaded;
  logic [5:0] address0 = '0;
  logic [15:0] q0;
  word_t model [32];
  int m_ptr = 0;
  bit m_full = 0;
  word_t sb [$];
  word_t exp_w, held;
  int n_pass = 0, n_total = 0;

  encoder_layer_2_attention_self_key_bias_loader dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready), .reload(reload), .loaded(loaded),
    .address0(address0), .ce0(ce0), .q0(q0)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input bit v, input word_t d, input bit rl = 0);
    data_in[0] = d;
    data_in_valid = v;
    reload = rl;
    step();
    if (rl) begin
      m_ptr = 0;
      m_full = 0;
    end else if (v && !m_full) begin
      model[m_ptr] = d;
      if (m_ptr == 31) begin
        m_ptr = 0;
        m_full = 1;
      end else m_ptr++;
    end
    data_in_valid = 0;
    reload = 0;
  endtask

  task automatic issue_read(input int a);
    address0 = 6'(a);
    ce0 = 1;
    sb.push_back(model[a]);
    step();
    step();
    ce0 = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    step();
    step();
    n_total++; if (data_in_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", data_in_ready); else n_pass++;
    n_total++; if (loaded !== 1'b0) $display("FAIL reset_loaded got %b exp 0", loaded); else n_pass++;
    n_total++; if (q0 !== 16'h0) $display("FAIL reset_q0 got %h exp 0000", q0); else n_pass++;
    rst = 0;
  endtask

  task automatic test_full_load();
    int nrdy = 0;
    for (int i = 0; i < 32; i++) begin
      if (data_in_ready !== 1'b1) nrdy++;
      drive_beat(1, 16'(16'h1000 + i));
    end
    n_total++; if (nrdy != 0) $display("FAIL full_ready_gaps got %0d exp 0", nrdy); else n_pass++;
    n_total++; if (loaded !== 1'b1) $display("FAIL full_loaded got %b exp 1", loaded); else n_pass++;
    n_total++; if (data_in_ready !== 1'b0) $display("FAIL full_ready got %b exp 0", data_in_ready); else n_pass++;
    issue_read(5);
    exp_w = sb.pop_front();
    n_total++; if (q0 !== exp_w) $display("FAIL full_rd5 got %h exp %h", q0, exp_w); else n_pass++;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) begin
      drive_beat(1, 16'hDEAD);
      n_total++; if (data_in_ready !== 1'b0) $display("FAIL ovf_ready got %b exp 0", data_in_ready); else n_pass++;
    end
    for (int a = 0; a < 4; a++) begin
      issue_read(a);
      exp_w = sb.pop_front();
      n_total++; if (q0 !== exp_w) $display("FAIL ovf_rd%0d got %h exp %h", a, q0, exp_w); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int cyc = 0;
    drive_beat(0, '0, 1);
    n_total++; if (loaded !== 1'b0) $display("FAIL bp_reload_loaded got %b exp 0", loaded); else n_pass++;
    while (!m_full && cyc < 400) begin
      drive_beat(1'($urandom_range(0, 1)), 16'(16'h3000 + m_ptr));
      cyc++;
      n_total++; if (loaded !== m_full) $display("FAIL bp_loaded got %b exp %b", loaded, m_full); else n_pass++;
    end
    n_total++; if (!m_full) $display("FAIL bp_timeout got %0d exp <400", cyc); else n_pass++;
    for (int a = 0; a < 32; a++) begin
      issue_read(a);
      exp_w = sb.pop_front();
      n_total++; if (q0 !== exp_w) $display("FAIL bp_rd%0d got %h exp %h", a, q0, exp_w); else n_pass++;
    end
  endtask

  task automatic test_reload_mid();
    drive_beat(0, '0, 1);
    for (int i = 0; i < 10; i++) drive_beat(1, 16'(16'h4000 + i));
    drive_beat(1, 16'hBEEF, 1);
    for (int i = 0; i < 32; i++) drive_beat(1, 16'(16'h2000 + i));
    n_total++; if (loaded !== 1'b1) $display("FAIL rl_loaded got %b exp 1", loaded); else n_pass++;
    for (int a = 0; a < 32; a++) begin
      issue_read(a);
      exp_w = sb.pop_front();
      n_total++; if (q0 !== exp_w) $display("FAIL rl_rd%0d got %h exp %h", a, q0, exp_w); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    drive_beat(0, '0, 1);
    for (int i = 0; i < 7; i++) drive_beat(1, 16'(16'h5000 + i));
    issue_read(3);
    exp_w = sb.pop_front();
    n_total++; if (q0 !== exp_w) $display("FAIL rst_pre_rd got %h exp %h", q0, exp_w); else n_pass++;
    rst = 1;
    step();
    rst = 0;
    m_ptr = 0;
    m_full = 0;
    n_total++; if (q0 !== 16'h0) $display("FAIL rst_q0 got %h exp 0000", q0); else n_pass++;
    n_total++; if (loaded !== 1'b0) $display("FAIL rst_loaded got %b exp 0", loaded); else n_pass++;
    n_total++; if (data_in_ready !== 1'b1) $display("FAIL rst_ready got %b exp 1", data_in_ready); else n_pass++;
    drive_beat(1, 16'h6000);
    for (int a = 0; a < 2; a++) begin
      issue_read(a);
      exp_w = sb.pop_front();
      n_total++; if (q0 !== exp_w) $display("FAIL rst_rd%0d got %h exp %h", a, q0, exp_w); else n_pass++;
    end
  endtask

  task automatic test_ce0_collision();
    drive_beat(0, '0, 1);
    for (int i = 0; i < 4; i++) drive_beat(1, 16'(16'h7000 + i));
    address0 = 6'd4;
    ce0 = 1;
    sb.push_back(model[4]);
    data_in[0] = 16'h7777;
    data_in_valid = 1;
    step();
    data_in_valid = 0;
    model[4] = 16'h7777;
    m_ptr = 5;
    step();
    exp_w = sb.pop_front();
    held = exp_w;
    n_total++; if (q0 !== exp_w) $display("FAIL coll_old got %h exp %h", q0, exp_w); else n_pass++;
    ce0 = 0;
    for (int i = 0; i < 3; i++) begin
      address0 = 6'(i);
      step();
      n_total++; if (q0 !== held) $display("FAIL hold%0d got %h exp %h", i, q0, held); else n_pass++;
    end
    ce0 = 1;
    step();
    ce0 = 0;
    n_total++; if (q0 !== model[4]) $display("FAIL coll_new got %h exp %h", q0, model[4]); else n_pass++;
  endtask

  initial begin
    data_in[0] = '0;
    test_reset();
    test_full_load();
    test_overflow();
    test_backpressure();
    test_reload_mid();
    test_reset_mid();
    test_ce0_collision();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
